// File: rtl/neural_regs_pkg.sv
// Shared constants for the neural-network register bank.
// Holds the read address map, the run-control state encoding, the status
// word bit positions and the register-array indices of the offset and input
// words. No ports.
package neural_regs_pkg;

  // Register-array layout: coefficients 0..19, then offset, then input.
  localparam int IDX_OFFSET = 20;
  localparam int IDX_INPUT  = 21;

  // Read address map (byte addresses).
  localparam logic [8:0] ADDR_STATUS     = 9'h000;
  localparam logic [8:0] ADDR_COEFF_BASE = 9'h00C;
  localparam logic [8:0] ADDR_OFFSET     = 9'h05C;
  localparam logic [8:0] ADDR_INPUT      = 9'h060;
  localparam logic [8:0] ADDR_RESULT     = 9'h064;
  localparam logic [8:0] ADDR_RSVD       = 9'h068;

  // Status word bit positions.
  localparam int ST_BUSY        = 0;
  localparam int ST_DONE        = 1;
  localparam int ST_ERR_BUSY    = 2;
  localparam int ST_ERR_TIMEOUT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_e;

  // Byte address of coefficient idx (word-spaced from the base).
  function automatic logic [8:0] coeff_addr(input int idx);
    return ADDR_COEFF_BASE + 9'(idx * 4);
  endfunction

endpackage

// File: rtl/neural_start_fsm.sv
// Run-control for the neuron datapath: IDLE -> LAUNCH -> RUN -> IDLE,
// a timeout counter for RUN, result capture and the sticky status flags.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_cmd_i           start command (start address match qualified by write)
//   wr_drop_i             a register write was attempted while busy
//   stat_rd_i             status register read (read-to-clear)
//   neuron_done_i         datapath completion pulse
//   neuron_result_i       datapath result, valid with neuron_done_i
//   busy_o                high in LAUNCH and RUN
//   start_neuron_o        one-cycle launch pulse (LAUNCH state)
//   done_o, err_busy_o, err_timeout_o  sticky flags
//   result_o              last captured datapath result
module neural_start_fsm
  import neural_regs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_cmd_i,
  input  logic              wr_drop_i,
  input  logic              stat_rd_i,
  input  logic              neuron_done_i,
  input  logic [DATA_W-1:0] neuron_result_i,
  output logic              busy_o,
  output logic              start_neuron_o,
  output logic              done_o,
  output logic              err_busy_o,
  output logic              err_timeout_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              err_busy_q, err_busy_d;
  logic              err_to_q, err_to_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_busy_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_busy_q <= err_busy_d;
      err_to_q   <= err_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = done_q;
    err_busy_d = err_busy_q;
    err_to_d   = err_to_q;

    // Clear first so that any set event below in the same cycle wins.
    if (stat_rd_i) begin
      done_d     = 1'b0;
      err_busy_d = 1'b0;
      err_to_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_cmd_i) begin
          state_d  = LAUNCH;
          done_d   = 1'b0;
          err_to_d = 1'b0;
        end
      end
      LAUNCH: begin
        state_d = RUN;
        cnt_d   = '0;
        if (start_cmd_i) err_busy_d = 1'b1;
      end
      RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (start_cmd_i) err_busy_d = 1'b1;
        if (neuron_done_i) begin
          result_d = neuron_result_i;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d   = 1'b1;
          err_to_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_drop_i) err_busy_d = 1'b1;
  end

  // Decoded straight from the state register so reset drops them at once.
  assign busy_o         = (state_q != IDLE);
  assign start_neuron_o = (state_q == LAUNCH);
  assign done_o         = done_q;
  assign err_busy_o     = err_busy_q;
  assign err_timeout_o  = err_to_q;
  assign result_o       = result_q;

endmodule

// File: rtl/neural_register_bank.sv
// Register bank for the neural-network peripheral: 20 coefficients, offset
// and input word written through decoder one-hot enables, a registered read
// mux over a fixed address map, and the run-control FSM.
// Ports:
//   Clock, Reset                clock, asynchronous active-high reset
//   Address, Write, Read        bus address and strobes
//   WriteData                   bus write data
//   EnableRegister              one-hot write enables [0..19] coeff, [20] offset, [21] input
//   EnableStart                 start address match
//   ReadData, ReadValid         registered read data and its one-cycle valid
//   Coeff, Offset, Entrada      stored register contents
//   StartNeuron                 launch pulse to datapath
//   NeuronDone, NeuronResult    datapath completion and result
//   Busy, IrqDone               run in progress, sticky done level
module neural_register_bank
  import neural_regs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_COEFF = 20,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [8:0]                Address,
  input  logic                      Write,
  input  logic                      Read,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic [NUM_COEFF+1:0]      EnableRegister,
  input  logic                      EnableStart,
  output logic [DATA_W-1:0]         ReadData,
  output logic                      ReadValid,
  output logic [NUM_COEFF*DATA_W-1:0] Coeff,
  output logic [DATA_W-1:0]         Offset,
  output logic [DATA_W-1:0]         Entrada,
  output logic                      StartNeuron,
  input  logic                      NeuronDone,
  input  logic [DATA_W-1:0]         NeuronResult,
  output logic                      Busy,
  output logic                      IrqDone
);

  localparam int NUM_REGS = NUM_COEFF + 2;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              busy;
  logic              done;
  logic              err_busy;
  logic              err_to;
  logic [DATA_W-1:0] result;
  logic              start_cmd;
  logic              wr_drop;
  logic              stat_rd;

  assign start_cmd = EnableStart & Write;
  assign wr_drop   = (|EnableRegister) & busy;
  assign stat_rd   = Read & (Address == ADDR_STATUS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          regs_q[gi] <= '0;
        end else if (EnableRegister[gi] && !busy) begin
          regs_q[gi] <= WriteData;
        end
      end
    end
    for (gi = 0; gi < NUM_COEFF; gi++) begin : g_coeff_out
      assign Coeff[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign Offset  = regs_q[IDX_OFFSET];
  assign Entrada = regs_q[IDX_INPUT];

  neural_start_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk_i           (Clock),
    .rst_i           (Reset),
    .start_cmd_i     (start_cmd),
    .wr_drop_i       (wr_drop),
    .stat_rd_i       (stat_rd),
    .neuron_done_i   (NeuronDone),
    .neuron_result_i (NeuronResult),
    .busy_o          (busy),
    .start_neuron_o  (StartNeuron),
    .done_o          (done),
    .err_busy_o      (err_busy),
    .err_timeout_o   (err_to),
    .result_o        (result)
  );

  // Read mux; unmapped, misaligned and reserved addresses return zero.
  always_comb begin
    rd_data_d = '0;
    if (Address == ADDR_STATUS) begin
      rd_data_d[ST_BUSY]        = busy;
      rd_data_d[ST_DONE]        = done;
      rd_data_d[ST_ERR_BUSY]    = err_busy;
      rd_data_d[ST_ERR_TIMEOUT] = err_to;
    end
    for (int i = 0; i < NUM_COEFF; i++) begin
      if (Address == coeff_addr(i)) rd_data_d = regs_q[i];
    end
    if (Address == ADDR_OFFSET) rd_data_d = regs_q[IDX_OFFSET];
    if (Address == ADDR_INPUT)  rd_data_d = regs_q[IDX_INPUT];
    if (Address == ADDR_RESULT) rd_data_d = result;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= Read;
      if (Read) rd_data_q <= rd_data_d;
    end
  end

  assign ReadData  = rd_data_q;
  assign ReadValid = rd_valid_q;
  assign Busy      = busy;
  assign IrqDone   = done;

endmodule

// File: tb/tb_neural_register_bank.sv
module tb_neural_register_bank;

  localparam int DW = 32;
  localparam int NC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [8:0]    addr;
  logic          wr, rd;
  logic [DW-1:0] wdata;
  logic [NC+1:0] en_reg;
  logic          en_start;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [NC*DW-1:0] coeff;
  logic [DW-1:0] offset, entrada;
  logic          start_neuron;
  logic          ndone;
  logic [DW-1:0] nresult;
  logic          busy, irq;

  neural_register_bank #(.DATA_W(DW), .NUM_COEFF(NC), .TIMEOUT(8)) dut (
    .Clock          (clk),
    .Reset          (rst),
    .Address        (addr),
    .Write          (wr),
    .Read           (rd),
    .WriteData      (wdata),
    .EnableRegister (en_reg),
    .EnableStart    (en_start),
    .ReadData       (rdata),
    .ReadValid      (rvalid),
    .Coeff          (coeff),
    .Offset         (offset),
    .Entrada        (entrada),
    .StartNeuron    (start_neuron),
    .NeuronDone     (ndone),
    .NeuronResult   (nresult),
    .Busy           (busy),
    .IrqDone        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input logic [DW-1:0] d);
    en_reg = '0;
    en_reg[idx] = 1'b1;
    wr = 1'b1;
    wdata = d;
    step();
    wr = 1'b0;
    en_reg = '0;
  endtask

  task automatic do_read(input logic [8:0] a, output logic [DW-1:0] d, output logic v);
    rd = 1'b1;
    addr = a;
    step();
    rd = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  task automatic do_start();
    wr = 1'b1;
    en_start = 1'b1;
    addr = 9'h004;
    step();
    wr = 1'b0;
    en_start = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    int            idx;
    logic [DW-1:0] wdata;
    logic [8:0]    raddr;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [DW-1:0] model [NC+2];
  logic [DW-1:0] d;
  logic          v;
  int            busy_cnt, start_cnt, start_at, fall_at;
  logic [8:0]    zaddrs[6];

  initial begin
    vecs[0] = '{1'b1, 3,  32'h12345678, 9'h018, 32'h12345678};
    vecs[1] = '{1'b1, 0,  32'hA5A5A5A5, 9'h00C, 32'hA5A5A5A5};
    vecs[2] = '{1'b1, 19, 32'hDEADBEEF, 9'h058, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 21, 32'h00C0FFEE, 9'h060, 32'h00C0FFEE};
    vecs[4] = '{1'b1, 7,  32'h0BADF00D, 9'h018, 32'h12345678};
    vecs[5] = '{1'b0, 0,  32'h0,        9'h028, 32'h0BADF00D};
    vecs[6] = '{1'b0, 0,  32'h0,        9'h068, 32'h0};
    vecs[7] = '{1'b0, 0,  32'h0,        9'h019, 32'h0};
    vecs[8] = '{1'b0, 0,  32'h0,        9'h1FC, 32'h0};
    vecs[9] = '{1'b0, 0,  32'h0,        9'h05C, 32'h0};
    for (int i = 0; i < NC + 2; i++) model[i] = '0;

    rst = 1'b1; addr = '0; wr = 0; rd = 0; wdata = '0; en_reg = '0;
    en_start = 0; ndone = 0; nresult = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start_neuron), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_coeff_or", 32'(|coeff), 32'd0);

    // Table: optional write, then read back
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].idx, vecs[i].wdata);
        model[vecs[i].idx] = vecs[i].wdata;
      end
      do_read(vecs[i].raddr, d, v);
      $display("vec %0d addr=%h rdata=%h exp=%h", i, vecs[i].raddr, d, vecs[i].exp);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_rvalid", i), 32'(v), 32'd1);
      step();
      chk($sformatf("vec%0d_rvalid_drop", i), 32'(rvalid), 32'd0);
    end

    // Read of a register in the cycle it is written returns the old value
    en_reg = '0; en_reg[3] = 1'b1; wdata = 32'h77777777; rd = 1'b1; addr = 9'h018;
    step();
    en_reg = '0; rd = 1'b0;
    model[3] = 32'h77777777;
    $display("same-cycle write/read rdata=%h", rdata);
    chk("same_cycle_old", rdata, 32'h12345678);

    for (int i = 0; i < NC; i++)
      chk($sformatf("coeff%0d", i), coeff[i*DW +: DW], model[i]);
    chk("offset_zero", offset, 32'd0);
    chk("entrada", entrada, model[21]);

    // Normal run: NeuronDone four cycles after StartNeuron
    do_start();
    busy_cnt = 0; start_cnt = 0; start_at = -1;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cnt++;
      if (start_neuron) begin start_cnt++; start_at = k; end
      ndone = (k == 4);
      nresult = (k == 4) ? 32'h0000ABCD : 32'h0;
      step();
    end
    ndone = 0;
    $display("run1 busy_cycles=%0d start_pulses=%0d", busy_cnt, start_cnt);
    chk("run1_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("run1_start_pulses", 32'(start_cnt), 32'd1);
    chk("run1_start_at", 32'(start_at), 32'd0);
    chk("run1_irq", 32'(irq), 32'd1);
    do_read(9'h064, d, v);
    chk("run1_result", d, 32'h0000ABCD);
    do_read(9'h000, d, v);
    chk("run1_status1", d, 32'h2);
    do_read(9'h000, d, v);
    chk("run1_status2", d, 32'h0);

    // NeuronDone while idle is ignored
    ndone = 1'b1; nresult = 32'h99999999;
    step();
    ndone = 1'b0;
    chk("idle_done_irq", 32'(irq), 32'd0);
    do_read(9'h064, d, v);
    chk("idle_done_result", d, 32'h0000ABCD);

    // Write and restart during a run are dropped
    do_start();
    start_cnt = 0;
    if (start_neuron) start_cnt++;
    en_reg = '0; en_reg[20] = 1'b1; wdata = 32'h0000FFFF;
    step();
    en_reg = '0;
    if (start_neuron) start_cnt++;
    do_start();
    if (start_neuron) start_cnt++;
    step();
    if (start_neuron) start_cnt++;
    ndone = 1'b1; nresult = 32'h00001111;
    step();
    ndone = 1'b0;
    $display("run2 start_pulses=%0d offset=%h", start_cnt, offset);
    chk("run2_offset", offset, 32'd0);
    chk("run2_start_pulses", 32'(start_cnt), 32'd1);
    do_read(9'h000, d, v);
    chk("run2_status", d, 32'h6);

    // Timeout with no NeuronDone
    do_start();
    busy_cnt = 0; fall_at = -1;
    for (int k = 0; k < 14; k++) begin
      if (busy) busy_cnt++;
      else if (fall_at < 0) fall_at = k;
      step();
    end
    $display("timeout busy_cycles=%0d fall_at=%0d", busy_cnt, fall_at);
    chk("to_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("to_fall_at", 32'(fall_at), 32'd9);
    do_read(9'h000, d, v);
    chk("to_status", d, 32'hA);
    do_read(9'h064, d, v);
    chk("to_result", d, 32'h00001111);

    // Status read in the same cycle as NeuronDone: the set wins
    do_start();
    step();
    rd = 1'b1; addr = 9'h000; ndone = 1'b1; nresult = 32'h00002222;
    step();
    rd = 1'b0; ndone = 1'b0;
    $display("rd+done status=%h irq=%0d", rdata, irq);
    chk("rdclr_old_status", rdata, 32'h1);
    chk("rdclr_irq", 32'(irq), 32'd1);
    do_read(9'h000, d, v);
    chk("rdclr_status", d, 32'h2);

    // Reset in the middle of a run
    do_start();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_start", 32'(start_neuron), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_coeff_or", 32'(|coeff), 32'd0);
    chk("mrst_entrada", entrada, 32'd0);
    zaddrs[0] = 9'h000; zaddrs[1] = 9'h018; zaddrs[2] = 9'h058;
    zaddrs[3] = 9'h05C; zaddrs[4] = 9'h060; zaddrs[5] = 9'h064;
    for (int i = 0; i < 6; i++) begin
      do_read(zaddrs[i], d, v);
      $display("post-reset read addr=%h rdata=%h", zaddrs[i], d);
      chk($sformatf("mrst_read_%h", zaddrs[i]), d, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neural_register_bank.md
# neural_register_bank

Register bank and run-control stage directly downstream of the write-address decoder in the neural-network peripheral. It holds the 20 training coefficients, the offset coefficient and the input word. It launches the neuron datapath on a start command, captures its result and exposes status and readback to the bus. Register writes are gated by the decoder's one-hot enables; reads use a fixed internal address map.

## Interface
- DATA_W, 32: width of every stored register and bus data word.
- NUM_COEFF, 20: number of training coefficients; must match decoder enables 0..19.
- TIMEOUT, 1024: maximum cycles in RUN before forced abort; range 2..65535.
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Address  in  9  bus byte address, used for reads and for start qualification.
- Write  in  1  bus write strobe, one cycle per access.
- Read  in  1  bus read strobe, one cycle per access; Read and Write are never high together.
- WriteData  in  DATA_W  bus write data.
- EnableRegister  in  NUM_COEFF+2  one-hot write enables from decoder: [0..19] coefficients, [20] offset, [21] input.
- EnableStart  in  1  decoder start-address match; not write-qualified.
- ReadData  out  DATA_W  registered read data.
- ReadValid  out  1  one-cycle pulse, ReadData valid.
- Coeff  out  NUM_COEFF*DATA_W  flattened coefficients; coefficient i at bits [i*DATA_W +: DATA_W].
- Offset  out  DATA_W  offset coefficient.
- Entrada  out  DATA_W  input word.
- StartNeuron  out  1  one-cycle launch pulse to datapath.
- NeuronDone  in  1  datapath completion pulse.
- NeuronResult  in  DATA_W  datapath result, valid with NeuronDone.
- Busy  out  1  high while a run is in progress.
- IrqDone  out  1  level; equals sticky Done bit.

## Operation
- Write: if EnableRegister[k] is high and Busy is low, register k loads WriteData at the next edge. If Busy is high, the write is dropped and sticky ErrBusy is set.
- Start: a command is EnableStart & Write, with any WriteData. From IDLE it launches a run. From any other state it is ignored and sets ErrBusy.
- FSM states:
  - IDLE: on start command go to LAUNCH.
  - LAUNCH: StartNeuron=1 for exactly this cycle; go to RUN; clear timeout counter.
  - RUN: Busy=1. On NeuronDone, capture NeuronResult into Result, set Done, go to IDLE. Otherwise, when the counter reaches TIMEOUT-1, set Done and ErrTimeout, leave Result unchanged, go to IDLE.
- Busy is high in LAUNCH and RUN.
- NeuronDone outside RUN is ignored.
- Read map (ReadData loaded one cycle after Read):
  - 0x000: status {..., ErrTimeout[3], ErrBusy[2], Done[1], Busy[0]}, zero-extended.
  - 0x00C..0x058: coefficients 0..19.
  - 0x05C: offset.
  - 0x060: input.
  - 0x064: Result.
  - 0x068: reads 0.
  - All other addresses read 0.
- Status read is read-to-clear for Done, ErrBusy and ErrTimeout. A set event in the same cycle wins over the clear.
- A new start command clears Done and ErrTimeout on entry to LAUNCH.

## Timing
- Reset values: all registers, Result, ReadData and flags are 0; ReadValid=0, StartNeuron=0, Busy=0, IrqDone=0; FSM in IDLE.
- Write latency: 1 cycle, so Coeff/Offset/Entrada show the new value on the cycle after Write.
- Read latency: 1 cycle; ReadValid pulses for exactly one cycle per Read.
- Start latency: command at cycle N gives StartNeuron at N+1 and Busy from N+1.
- NeuronDone at cycle M: Result and Done are visible at M+1, Busy is low at M+1, and a new start is accepted from M+1.
- Timeout: Done/ErrTimeout are visible TIMEOUT cycles after entering RUN.
- Reading a register in the same cycle it is written returns the old value.
- Reset mid-run: immediate return to IDLE; StartNeuron and Busy fall asynchronously.

## Structure
- Package neural_regs_pkg holds:
  - read address constants;
  - FSM state enum (IDLE, LAUNCH, RUN);
  - status bit indices;
  - index constants for offset (20) and input (21).
- Sub-module neural_start_fsm contains the FSM, timeout counter and flag logic. The top level holds the register array and read mux.

## Test plan
- Write 0x12345678 with EnableRegister[3] high, then read 0x018 → ReadData=0x12345678 with ReadValid one cycle after Read; Coeff[3] updated; all other registers still 0.
- Start command, datapath returns NeuronDone with 0x0000ABCD four cycles later → StartNeuron single pulse at N+1; Busy high for 5 cycles; read 0x064 → 0x0000ABCD; status read → 0x2, then a second status read → 0x0.
- During RUN, write EnableRegister[20] with 0xFFFF and issue a second start → Offset stays 0; one StartNeuron pulse only; status bit2 set.
- With TIMEOUT=8 and no NeuronDone → Busy falls 8 cycles after entering RUN; status=0xA; Result unchanged.
- Status read in the same cycle NeuronDone arrives → Done remains 1 afterwards.
- Assert Reset while in RUN → Busy, StartNeuron and IrqDone are 0 immediately; all readbacks are 0.
